// File: rtl/adc_spi_cfg_sequencer.sv
// Drives 3-wire SPI register writes into ADC0: a boot-table walk on start,
// plus runtime single writes accepted only while idle (table walk has priority).
module adc_spi_cfg_sequencer #(
    parameter int unsigned NUM_REGS  = 4,
    parameter int unsigned IDX_W     = 8,
    parameter int unsigned SCLK_HALF = 50,
    parameter int unsigned GAP_CYC   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [12:0]      tbl_addr,
    input  logic [7:0]       tbl_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [12:0]      wr_addr,
    input  logic [7:0]       wr_data,
    output logic             ADC0_CSB,
    output logic             ADC0_SCLK,
    output logic             ADC0_SDIO
);
    localparam int unsigned FRAME_W = 24;
    localparam int unsigned PERIOD  = 2 * SCLK_HALF;
    localparam int unsigned CNT_MAX = (PERIOD > GAP_CYC) ? PERIOD : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = 5;

    typedef enum logic [2:0] {IDLE, LOAD, CS_SETUP, SHIFT, CS_HOLD, GAP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic               mode_tbl_q, mode_tbl_d;
    logic [IDX_W-1:0]   idx_d;
    logic               busy_d, done_d, csb_d, sclk_d, sdio_d;

    // Single-write handshake; start in the same cycle takes precedence.
    assign wr_ready = (state_q == IDLE) && !start;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            mode_tbl_q <= 1'b0;
            tbl_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ADC0_CSB   <= 1'b1;
            ADC0_SCLK  <= 1'b0;
            ADC0_SDIO  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            mode_tbl_q <= mode_tbl_d;
            tbl_idx    <= idx_d;
            busy       <= busy_d;
            done       <= done_d;
            ADC0_CSB   <= csb_d;
            ADC0_SCLK  <= sclk_d;
            ADC0_SDIO  <= sdio_d;
        end
    end

    // Next-state logic; pin values are decoded from the next state so they land registered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        mode_tbl_d = mode_tbl_q;
        idx_d      = tbl_idx;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (start) begin
                    state_d    = LOAD;
                    idx_d      = '0;
                    mode_tbl_d = 1'b1;
                end else if (wr_valid) begin
                    sh_d       = {3'b000, wr_addr, wr_data};
                    state_d    = CS_SETUP;
                    mode_tbl_d = 1'b0;
                end
            end
            LOAD: begin
                sh_d    = {3'b000, tbl_addr, tbl_data};
                cnt_d   = '0;
                state_d = CS_SETUP;
            end
            CS_SETUP: begin
                if (cnt_q == CNT_W'(SCLK_HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                // Period end is the SCLK fall: advance the frame there, well away from the rise.
                if (cnt_q == CNT_W'(PERIOD - 1)) begin
                    cnt_d = '0;
                    sh_d  = {sh_q[FRAME_W-2:0], 1'b0};
                    if (bit_q == BIT_W'(FRAME_W - 1)) begin
                        state_d = CS_HOLD;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CS_HOLD: begin
                if (cnt_q == CNT_W'(SCLK_HALF - 1)) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d = '0;
                    if (mode_tbl_q && (tbl_idx < IDX_W'(NUM_REGS - 1))) begin
                        idx_d   = tbl_idx + IDX_W'(1);
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                        done_d  = mode_tbl_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        csb_d  = !((state_d == CS_SETUP) || (state_d == SHIFT) || (state_d == CS_HOLD));
        sclk_d = (state_d == SHIFT) && (cnt_d >= CNT_W'(SCLK_HALF));
        sdio_d = ((state_d == CS_SETUP) || (state_d == SHIFT)) ? sh_d[FRAME_W-1] : 1'b0;
    end
endmodule
